// File: rtl/sd_cmd_tx_pkg.sv
// rtl/sd_cmd_tx_pkg.sv - shared frame constants and FSM state type for the SD command transmitter
package sd_pkg;

    localparam int FRAME_LEN = 48;
    localparam int CRC_W     = 7;
    localparam int HEAD_W    = 40;

    localparam logic START_BIT = 1'b0;
    localparam logic TX_BIT    = 1'b1;
    localparam logic END_BIT   = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CRC_WAIT = 2'd1,
        ST_SHIFT    = 2'd2,
        ST_GAP      = 2'd3
    } sd_state_e;

endpackage

// File: rtl/sd_cmd_tx_if.sv
// rtl/sd_cmd_tx_if.sv - host-side request/status bundle of the SD command transmitter
interface sd_cmd_tx_if;

    logic        start;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        busy;
    logic        done;
    logic        crc_err;

    // Host controller FSM side
    modport master (
        output start, cmd_index, cmd_arg,
        input  busy, done, crc_err
    );

    // Transmitter side
    modport slave (
        input  start, cmd_index, cmd_arg,
        output busy, done, crc_err
    );

endinterface

// File: rtl/sd_cmd_shreg.sv
// rtl/sd_cmd_shreg.sv - 48-bit frame register, parallel load, shift-left on enable, MSB out
module sd_cmd_shreg
    import sd_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [FRAME_LEN-1:0] load_data,
    input  logic                 shift,
    output logic                 msb
);

    logic [FRAME_LEN-1:0] sr;

    // Load wins over shift; vacated LSBs fill with 1 so an over-shift reads as an idle line
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (load) begin
            sr <= load_data;
        end else if (shift) begin
            sr <= {sr[FRAME_LEN-2:0], 1'b1};
        end
    end

    assign msb = sr[FRAME_LEN-1];

endmodule

// File: rtl/sd_cmd_tx.sv
// rtl/sd_cmd_tx.sv - SD command frame builder and CMD line serialiser with CRC7 handoff
module sd_cmd_tx
    import sd_pkg::*;
#(
    parameter int CRC_TIMEOUT = 4,
    parameter int GAP_BITS    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    sd_cmd_tx_if.slave        hif,
    input  logic              sd_clk_en,
    output logic              crc_en,
    output logic [HEAD_W-1:0] crc_data,
    input  logic              crc_done,
    input  logic [CRC_W-1:0]  crc_in,
    output logic              cmd_out,
    output logic              cmd_oe
);

    localparam int TO_W  = $clog2(CRC_TIMEOUT + 1);
    localparam int GAP_W = $clog2(GAP_BITS + 1);

    sd_state_e  state, state_nxt;
    logic [5:0] bit_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic done_q, crc_err_q, busy_c;
    logic sr_load, sr_shift, sr_msb;
    logic accept, crc_hit, crc_timeout, shift_end, gap_last;

    // A start coinciding with the done pulse is dropped so the host sees done before a new frame begins
    assign accept      = (state == ST_IDLE) && hif.start && !done_q;
    assign crc_hit     = (state == ST_CRC_WAIT) && crc_done;
    assign crc_timeout = (state == ST_CRC_WAIT) && !crc_done && (to_cnt == TO_W'(CRC_TIMEOUT - 1));
    // cmd_oe high with bit_cnt 0 means the end bit has been on the wire for a full SD clock
    assign shift_end   = (state == ST_SHIFT) && sd_clk_en && cmd_oe && (bit_cnt == 6'd0);
    assign gap_last    = (state == ST_GAP) && sd_clk_en && (gap_cnt == GAP_W'(GAP_BITS - 1));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (accept) state_nxt = ST_CRC_WAIT;
            ST_CRC_WAIT: begin
                if (crc_hit) begin
                    state_nxt = ST_SHIFT;
                end else if (crc_timeout) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT:    if (shift_end) state_nxt = ST_GAP;
            ST_GAP:      if (gap_last) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // State-decoded outputs and shift register controls
    always_comb begin
        crc_en   = (state == ST_CRC_WAIT);
        busy_c   = (state != ST_IDLE);
        sr_load  = crc_hit;
        sr_shift = (state == ST_SHIFT) && sd_clk_en && !shift_end;
    end

    // Datapath: request latch, counters, registered line drivers and status pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crc_data  <= '0;
            to_cnt    <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            cmd_out   <= 1'b1;
            cmd_oe    <= 1'b0;
            done_q    <= 1'b0;
            crc_err_q <= 1'b0;
        end else begin
            done_q    <= gap_last;
            crc_err_q <= crc_timeout;
            if (accept) begin
                crc_data <= {START_BIT, TX_BIT, hif.cmd_index, hif.cmd_arg};
                to_cnt   <= '0;
            end
            if (state == ST_CRC_WAIT) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
            if (crc_hit) begin
                bit_cnt <= 6'(FRAME_LEN - 1);
            end
            if ((state == ST_SHIFT) && sd_clk_en) begin
                if (!cmd_oe) begin
                    cmd_oe  <= 1'b1;
                    cmd_out <= sr_msb;
                end else if (bit_cnt == 6'd0) begin
                    cmd_oe  <= 1'b0;
                    cmd_out <= 1'b1;
                    gap_cnt <= '0;
                end else begin
                    bit_cnt <= bit_cnt - 6'd1;
                    cmd_out <= sr_msb;
                end
            end
            if ((state == ST_GAP) && sd_clk_en) begin
                gap_cnt <= gap_cnt + GAP_W'(1);
            end
        end
    end

    sd_cmd_shreg u_shreg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (sr_load),
        .load_data ({crc_data, crc_in, END_BIT}),
        .shift     (sr_shift),
        .msb       (sr_msb)
    );

    assign hif.busy    = busy_c;
    assign hif.done    = done_q;
    assign hif.crc_err = crc_err_q;

endmodule

// File: tb/tb_sd_cmd_tx.sv
// tb/tb_sd_cmd_tx.sv - scoreboard bench for sd_cmd_tx with a behavioural CRC7 unit
module tb_sd_cmd_tx;
    import sd_pkg::*;

    localparam int CRC_TIMEOUT = 4;
    localparam int GAP_BITS    = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sd_clk_en, crc_en, crc_done, cmd_out, cmd_oe;
    logic [HEAD_W-1:0] crc_data;
    logic [CRC_W-1:0]  crc_in;

    sd_cmd_tx_if hif ();

    sd_cmd_tx #(.CRC_TIMEOUT(CRC_TIMEOUT), .GAP_BITS(GAP_BITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hif       (hif),
        .sd_clk_en (sd_clk_en),
        .crc_en    (crc_en),
        .crc_data  (crc_data),
        .crc_done  (crc_done),
        .crc_in    (crc_in),
        .cmd_out   (cmd_out),
        .cmd_oe    (cmd_oe)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [47:0] sb_q[$];

    int  div = 1;
    bit  crc_silent = 1'b0;
    int  rx_bits = 0;
    bit  rx_open = 1'b0;
    bit  in_frame = 1'b0;
    int  tick_idx = 0;
    int  done_ticks = 0;
    int  unstable = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    // Line monitor, SD clock enable generator and CRC7 unit model, all on the falling edge
    initial begin
        int cyc;
        int crc_cnt;
        logic [47:0] rx_sr;
        logic [47:0] exp;
        logic last_out;
        cyc = 0; crc_cnt = 0; rx_sr = '0; last_out = 1'b1;
        sd_clk_en = 1'b0; crc_done = 1'b0; crc_in = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rx_open = 1'b0;
                in_frame = 1'b0;
            end else begin
                if (!sd_clk_en && (cmd_out !== last_out)) unstable++;
                if (sd_clk_en) begin
                    if (cmd_oe) begin
                        if (!in_frame) begin
                            in_frame = 1'b1; rx_open = 1'b1; tick_idx = 0; rx_bits = 0;
                        end else begin
                            tick_idx++;
                        end
                        rx_sr = {rx_sr[46:0], cmd_out};
                        rx_bits++;
                    end else if (in_frame) begin
                        tick_idx++;
                        if (rx_open) begin
                            rx_open = 1'b0;
                            chk("release_level", {63'd0, cmd_out}, 64'd1);
                            chk("oe_ticks", rx_bits, 48);
                            if (sb_q.size() == 0) begin
                                chk("unexpected_frame", rx_sr, 48'd0);
                            end else begin
                                exp = sb_q.pop_front();
                                chk("frame", rx_sr, exp);
                            end
                            rx_bits = 0;
                        end
                    end
                end
                if (hif.done && in_frame) begin
                    done_ticks = tick_idx;
                    in_frame = 1'b0;
                end
            end
            last_out = cmd_out;
            cyc++;
            sd_clk_en = ((cyc % div) == 0);
            if (crc_en) begin
                crc_cnt++;
                if (crc_cnt >= 2 && !crc_silent) begin
                    crc_done = 1'b1;
                    crc_in = crc7(crc_data);
                end
            end else begin
                crc_cnt = 0;
                crc_done = 1'b0;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [5:0] idx, input logic [31:0] arg, input logic [47:0] exp, input bit push);
        hif.start = 1'b1;
        hif.cmd_index = idx;
        hif.cmd_arg = arg;
        if (push) sb_q.push_back(exp);
        step();
        hif.start = 1'b0;
    endtask

    task automatic wait_done(input int max, input string tag);
        int n;
        n = 0;
        while (hif.done !== 1'b1 && n < max) begin
            step();
            n++;
        end
        chk(tag, {63'd0, hif.done}, 64'd1);
    endtask

    task automatic wait_bits(input int nb);
        int n;
        n = 0;
        while (rx_bits < nb && n < 1000) begin
            step();
            n++;
        end
        chk("reach_bit", rx_bits, nb);
    endtask

    initial begin
        int err_at, err_pulses, oe_seen;
        hif.start = 1'b0; hif.cmd_index = '0; hif.cmd_arg = '0;
        rst_n = 1'b0;
        repeat (3) step();
        chk("rst_cmd_out", {63'd0, cmd_out}, 64'd1);
        chk("rst_cmd_oe", {63'd0, cmd_oe}, 64'd0);
        chk("rst_crc_en", {63'd0, crc_en}, 64'd0);
        chk("rst_crc_data", crc_data, 64'd0);
        chk("rst_busy", {63'd0, hif.busy}, 64'd0);
        chk("rst_done", {63'd0, hif.done}, 64'd0);
        chk("rst_crc_err", {63'd0, hif.crc_err}, 64'd0);
        rst_n = 1'b1;
        step();

        // CMD0, tick every cycle
        div = 1;
        send(6'd0, 32'h0, 48'h400000000095, 1'b1);
        chk("busy_after_start", {63'd0, hif.busy}, 64'd1);
        chk("crc_en_after_start", {63'd0, crc_en}, 64'd1);
        chk("crc_data_cmd0", crc_data, 40'h4000000000);
        wait_done(1000, "cmd0_done");
        chk("busy_in_done", {63'd0, hif.busy}, 64'd0);
        step();
        chk("cmd0_ticks", done_ticks, 48 + GAP_BITS);
        chk("done_one_cycle", {63'd0, hif.done}, 64'd0);

        // CMD8 and CMD0 again with a tick every 4th cycle
        div = 4;
        send(6'd8, 32'h000001AA, 48'h48000001AA87, 1'b1);
        chk("crc_data_cmd8", crc_data, 40'h48000001AA);
        wait_done(1000, "cmd8_done");
        step();
        chk("cmd8_ticks", done_ticks, 48 + GAP_BITS);
        send(6'd0, 32'h0, 48'h400000000095, 1'b1);
        wait_done(1000, "cmd0_div4_done");
        step();
        chk("cmd0_div4_ticks", done_ticks, 48 + GAP_BITS);

        // CRC unit never answers
        div = 1;
        crc_silent = 1'b1;
        err_at = -1; err_pulses = 0; oe_seen = 0;
        send(6'd17, 32'h0, 48'h0, 1'b0);
        for (int k = 0; k < 12; k++) begin
            if (hif.crc_err) begin
                err_pulses++;
                if (err_at < 0) err_at = k;
            end
            if (cmd_oe) oe_seen++;
            step();
        end
        chk("crc_err_cycle", err_at, CRC_TIMEOUT);
        chk("crc_err_pulses", err_pulses, 1);
        chk("timeout_oe", oe_seen, 0);
        chk("timeout_busy", {63'd0, hif.busy}, 64'd0);
        chk("timeout_crc_en", {63'd0, crc_en}, 64'd0);
        crc_silent = 1'b0;

        // start mid-SHIFT and in the done cycle is ignored, the following cycle is taken
        send(6'd0, 32'h0, 48'h400000000095, 1'b1);
        wait_bits(10);
        send(6'h3F, 32'hDEADBEEF, 48'h0, 1'b0);
        chk("crc_data_hold", crc_data, 40'h4000000000);
        wait_done(1000, "pre_ignore_done");
        hif.start = 1'b1; hif.cmd_index = 6'h3F; hif.cmd_arg = 32'hDEADBEEF;
        step();
        chk("start_in_done_ignored", {63'd0, hif.busy}, 64'd0);
        send(6'd17, 32'h0, 48'h510000000055, 1'b1);
        chk("start_after_done_taken", {63'd0, hif.busy}, 64'd1);
        wait_done(1000, "cmd17_done");
        step();

        // reset in the middle of a frame
        send(6'd8, 32'h000001AA, 48'h0, 1'b0);
        wait_bits(20);
        rst_n = 1'b0;
        step();
        chk("midrst_cmd_oe", {63'd0, cmd_oe}, 64'd0);
        chk("midrst_cmd_out", {63'd0, cmd_out}, 64'd1);
        chk("midrst_busy", {63'd0, hif.busy}, 64'd0);
        rst_n = 1'b1;
        step();
        send(6'd0, 32'h0, 48'h400000000095, 1'b1);
        wait_done(1000, "post_rst_done");
        step();
        chk("post_rst_ticks", done_ticks, 48 + GAP_BITS);

        repeat (4) step();
        chk("sb_drained", sb_q.size(), 0);
        chk("cmd_out_stable", unstable, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
